// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: control inputs, IM port and IF/ID register outputs.
// The slave modport is the fetch stage; the master modport drives it.
interface instr_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 48
);
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] im_instr;
  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               if_id_valid;
  logic               halted;
  logic               err_oob;

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  im_instr,
    output im_addr,
    output im_rd_en,
    output if_id_instr,
    output if_id_pc,
    output if_id_valid,
    output halted,
    output err_oob
  );

  modport master (
    output stall,
    output branch_taken,
    output branch_target,
    output im_instr,
    input  im_addr,
    input  im_rd_en,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_valid,
    input  halted,
    input  err_oob
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, IM read control and IF/ID register,
// with stall, branch redirect, HLT detection and out-of-range target trapping.
module instr_fetch #(
  parameter int          ADDR_W     = 16,
  parameter int          INSTR_W    = 48,
  parameter int          IM_DEPTH   = 8192,
  parameter logic [5:0]  HLT_OPCODE = 6'h3F
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // One extra bit so the bound compare also works when IM_DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(IM_DEPTH);
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(IM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                tgt_ok_s;
  logic                is_hlt_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_L);
  endfunction

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return (pc == PC_LAST) ? PC_ZERO : (pc + PC_ONE);
  endfunction

  assign tgt_ok_s = in_range(bus.branch_target);
  assign is_hlt_s = (bus.im_instr[INSTR_W-1 -: 6] == HLT_OPCODE);

  assign bus.im_addr     = pc_q;
  assign bus.im_rd_en    = ~rst & ~bus.stall & (state_q == ST_FETCH);
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = if_pc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.err_oob     = err_q;

  // Next-state logic: redirect beats stall, stall beats normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    err_d   = err_q;

    case (state_q)
      ST_FETCH: begin
        if (bus.branch_taken) begin
          valid_d = 1'b0;
          if (tgt_ok_s) begin
            pc_d = bus.branch_target;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HALTED;
          end
        end else if (bus.stall) begin
          pc_d    = pc_q;
          valid_d = valid_q;
        end else begin
          instr_d = bus.im_instr;
          if_pc_d = pc_q;
          valid_d = 1'b1;
          // HLT is delivered to decode, but fetch stops at its address.
          if (is_hlt_s) begin
            state_d = ST_HALTED;
          end else begin
            pc_d = next_pc(pc_q);
          end
        end
      end

      ST_HALTED: begin
        valid_d = 1'b0;
        if (bus.branch_taken) begin
          if (tgt_ok_s) begin
            pc_d    = bus.branch_target;
            state_d = ST_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_HALTED;
        end
      end

      default: begin
        state_d = ST_FETCH;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that overrides stall and redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_ZERO;
      instr_q <= {INSTR_W{1'b0}};
      if_pc_q <= PC_ZERO;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a falling-edge IM model holding IM[i]=i.
module tb_instr_fetch;

  logic clk;
  logic rst;
  logic hlt7;
  int   n_checks;
  int   n_fail;

  instr_fetch_if #(.ADDR_W(16), .INSTR_W(48)) bus ();

  instr_fetch #(
    .ADDR_W(16), .INSTR_W(48), .IM_DEPTH(8192), .HLT_OPCODE(6'h3F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [47:0] im_word(input logic [15:0] a);
    if (hlt7 && a == 16'd7) return {6'h3F, 42'd7};
    return {32'd0, a};
  endfunction

  // IM reads on the falling edge and holds its output when not enabled.
  always @(negedge clk) begin
    if (bus.im_rd_en) bus.im_instr <= im_word(bus.im_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cap(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, 64'(bus.if_id_valid), 64'd1);
    check({tag, "_pc"},    64'(bus.if_id_pc),    64'(pc));
    check({tag, "_instr"}, 64'(bus.if_id_instr), {48'd0, pc});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hlt7     = 1'b0;
    rst      = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'd0;

    tick();
    tick();
    check("rst_valid",  64'(bus.if_id_valid), 64'd0);
    check("rst_pc",     64'(bus.if_id_pc),    64'd0);
    check("rst_instr",  64'(bus.if_id_instr), 64'd0);
    check("rst_halted", 64'(bus.halted),      64'd0);
    check("rst_err",    64'(bus.err_oob),     64'd0);
    check("rst_rden",   64'(bus.im_rd_en),    64'd0);
    check("rst_addr",   64'(bus.im_addr),     64'd0);

    rst = 1'b0;
    #1;
    check("run_rden", 64'(bus.im_rd_en), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cap($sformatf("run%0d", i), 16'(i));
    end

    // Stall three cycles with pc=5.
    check("stall_addr", 64'(bus.im_addr), 64'd5);
    bus.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("stall%0d_rden", s), 64'(bus.im_rd_en), 64'd0);
      tick();
      chk_cap($sformatf("stall%0d", s), 16'd4);
    end
    bus.stall = 1'b0;
    tick();
    chk_cap("unstall", 16'd5);

    for (int k = 6; k < 16; k++) begin
      tick();
      chk_cap($sformatf("run%0d", k), 16'(k));
    end

    // Redirect with simultaneous stall at pc=0x10.
    check("br_addr", 64'(bus.im_addr), 64'h10);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0100;
    bus.stall         = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    check("br_bubble", 64'(bus.if_id_valid), 64'd0);
    check("br_addr2",  64'(bus.im_addr),     64'h100);
    tick();
    chk_cap("br_t0", 16'h0100);
    tick();
    chk_cap("br_t1", 16'h0101);

    // HLT at IM[7], reached by redirecting to 3.
    hlt7 = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'd3;
    tick();
    bus.branch_taken = 1'b0;
    check("h_bubble", 64'(bus.if_id_valid), 64'd0);
    for (int k = 3; k < 7; k++) begin
      tick();
      chk_cap($sformatf("h_run%0d", k), 16'(k));
    end
    tick();
    check("hlt_valid",  64'(bus.if_id_valid), 64'd1);
    check("hlt_pc",     64'(bus.if_id_pc),    64'd7);
    check("hlt_instr",  64'(bus.if_id_instr), {16'd0, 6'h3F, 42'd7});
    check("hlt_halted", 64'(bus.halted),      64'd1);
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    check("hlt_valid2", 64'(bus.if_id_valid), 64'd0);
    check("hlt_addr",   64'(bus.im_addr),     64'd7);
    check("hlt_rden",   64'(bus.im_rd_en),    64'd0);
    tick();
    check("hlt_addr2",  64'(bus.im_addr),     64'd7);
    check("hlt_halt2",  64'(bus.halted),      64'd1);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'd3;
    tick();
    bus.branch_taken = 1'b0;
    check("res_halted", 64'(bus.halted),      64'd0);
    check("res_valid",  64'(bus.if_id_valid), 64'd0);
    check("res_addr",   64'(bus.im_addr),     64'd3);
    tick();
    chk_cap("res3", 16'd3);
    tick();
    chk_cap("res4", 16'd4);
    hlt7 = 1'b0;

    // Wrap from IM_DEPTH-2.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h1FFE;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    chk_cap("wrap0", 16'h1FFE);
    tick();
    chk_cap("wrap1", 16'h1FFF);
    tick();
    chk_cap("wrap2", 16'h0000);

    // Out-of-range redirect.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h2000;
    tick();
    bus.branch_taken = 1'b0;
    check("oob_err",    64'(bus.err_oob),     64'd1);
    check("oob_halted", 64'(bus.halted),      64'd1);
    check("oob_valid",  64'(bus.if_id_valid), 64'd0);
    check("oob_addr",   64'(bus.im_addr),     64'd1);
    check("oob_rden",   64'(bus.im_rd_en),    64'd0);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0020;
    tick();
    bus.branch_taken = 1'b0;
    check("oob_res_halted", 64'(bus.halted),  64'd0);
    check("oob_sticky",     64'(bus.err_oob), 64'd1);
    tick();
    chk_cap("oob_res", 16'h0020);
    tick();
    chk_cap("oob_res1", 16'h0021);

    // Mid-stream reset beats stall and redirect.
    rst = 1'b1;
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0050;
    #1;
    check("mrst_rden", 64'(bus.im_rd_en), 64'd0);
    tick();
    check("mrst_err",    64'(bus.err_oob),     64'd0);
    check("mrst_halted", 64'(bus.halted),      64'd0);
    check("mrst_valid",  64'(bus.if_id_valid), 64'd0);
    check("mrst_addr",   64'(bus.im_addr),     64'd0);
    check("mrst_pc",     64'(bus.if_id_pc),    64'd0);
    rst = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    tick();
    chk_cap("post0", 16'd0);
    tick();
    chk_cap("post1", 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: owns the program counter and drives the instruction memory (IM) address and read enable. It captures the returned 48-bit word into the IF/ID pipeline register for the decode stage. It sits directly upstream of IM, whose read latches on the falling edge. A word addressed during a cycle is therefore available to this block at the next rising edge. The block handles stall, branch redirect, HLT detection and out-of-range targets.

## Interface

- ADDR_W, 16, PC / IM address width
- INSTR_W, 48, instruction width
- IM_DEPTH, 8192, number of IM words; legal PC range 0..IM_DEPTH-1
- HLT_OPCODE, 6'h3F, value of instr[47:42] that marks HLT

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents this cycle
- branch_taken  in  1  redirect fetch to branch_target
- branch_target  in  ADDR_W  redirect address
- im_instr  in  INSTR_W  IM read data, stable at rising edge
- im_addr  out  ADDR_W  IM address, equal to pc (combinational)
- im_rd_en  out  1  IM read enable
- if_id_instr  out  INSTR_W  captured instruction
- if_id_pc  out  ADDR_W  address of if_id_instr
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  high in HALTED state
- err_oob  out  1  sticky: redirect target >= IM_DEPTH

## Operation

- States: FETCH, HALTED. Reset enters FETCH.
- Read enable: im_rd_en = ~rst & ~stall & (state==FETCH).
- FETCH, highest priority first:
  - branch_taken, target < IM_DEPTH: pc <= target; if_id_valid <= 0, squashing the word fetched this cycle; IF/ID instr and pc are don't-care.
  - branch_taken, target >= IM_DEPTH: err_oob <= 1; state <= HALTED; if_id_valid <= 0; pc unchanged.
  - stall: pc, if_id_instr, if_id_pc, if_id_valid all hold.
  - otherwise: if_id_instr <= im_instr; if_id_pc <= pc; if_id_valid <= 1; pc <= (pc==IM_DEPTH-1) ? 0 : pc+1.
  - If the captured im_instr[47:42]==HLT_OPCODE: capture it as valid, state <= HALTED, pc holds.
- HALTED:
  - pc frozen; im_rd_en=0; if_id_valid <= 0 from the next edge onward.
  - stall has no effect.
  - branch_taken with an in-range target returns to FETCH with pc <= target, because the HLT was on the wrong path.
  - branch_taken with an out-of-range target sets err_oob and stays in HALTED.
- err_oob clears only on rst.
- PC arithmetic: unsigned, ADDR_W bits, wraps IM_DEPTH-1 -> 0. Upper address bits are never driven nonzero by the increment path.

## Timing

- Reset values, rst high at an edge: pc=0, state=FETCH, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, err_oob=0. im_rd_en=0 while rst is high.
- Reset asserted mid-operation discards any in-flight fetch or redirect. The reset edge wins over stall and branch_taken.
- Fetch latency:
  - The word at pc is read on the falling edge within cycle N and captured at the rising edge ending cycle N.
  - First valid if_id_valid appears one cycle after rst deasserts, with if_id_pc=0.
- Throughput: one instruction per cycle when not stalled.
- Stall: while stall=1, im_rd_en=0, so the IM output holds and no word is lost. Fetch resumes on the first cycle with stall=0, with no extra bubble.
- Redirect: one bubble; the first target instruction has if_id_valid=1 one cycle after the branch_taken edge.
- branch_taken and stall in the same cycle: the redirect is taken.
- halted rises on the edge that captures HLT. if_id_valid is 1 on that cycle and 0 on the following cycle.

## Test plan

- Reset, then free-run with IM[i]=i:
  - if_id_valid rises one cycle after rst falls.
  - if_id_pc and if_id_instr then run 0,1,2,... one per cycle.
- Stall for 3 cycles at pc=5:
  - im_rd_en=0 and IF/ID holds pc 4 for all 3 cycles.
  - pc 5 is captured on the first unstalled cycle.
- branch_taken with target 0x0100 at pc=0x10, stall asserted in the same cycle:
  - one bubble (valid=0), then if_id_pc=0x0100, then 0x0101.
- HLT at IM[7]:
  - if_id_pc=7 captured valid and halted=1.
  - if_id_valid=0 thereafter; pc and im_addr frozen at 7.
  - A later branch_taken to 3 resumes fetch from 3.
- Wrap: start at pc=IM_DEPTH-2 via redirect; the sequence 0x1FFE, 0x1FFF, 0x0000 is observed.
- Redirect to 0x2000: err_oob=1, halted=1, valid=0. rst clears both; rst asserted mid-stream restarts at pc 0.
